// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline types for the hazard scheduler.
//   fwd_sel_t  - decode comparator operand source (regfile / M / W)
//   md_state_t - mult/div occupancy FSM states
//   CNT_W      - width of the mult/div down counter
//   reg_match  - producer-to-source register match rule
package hazard_ctrl_pkg;

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_M  = 2'b01,
        FWD_W  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // $0 is hardwired, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic       we,
                                       input logic [4:0] wa,
                                       input logic [4:0] src);
        return we && (wa != 5'd0) && (wa == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_tracker.sv
// md_tracker: mult/div unit occupancy FSM.
//   clk, reset - core clock, synchronous active-high reset
//   start_i    - E-stage mult/div is leaving E this cycle (already qualified)
//   is_div_i   - 1 = divide, 0 = multiply
//   kill_i     - exception redirect, abandons any running operation
//   busy_o     - unit occupied (state register decode)
module md_tracker
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic is_div_i,
    input  logic kill_i,
    output logic busy_o
);

    // Counter holds remaining busy cycles minus one, so busy spans exactly N.
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    md_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || kill_i) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start_i) begin
                        state_q <= MD_BUSY;
                        cnt_q   <= is_div_i ? DIV_LOAD : MUL_LOAD;
                    end
                end
                MD_BUSY: begin
                    // Counts down through pipeline stalls: the unit runs freely.
                    if (cnt_q == '0) state_q <= MD_IDLE;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                default: begin
                    state_q <= MD_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and stall scheduler for the five-stage core.
//   Inputs : decode source regs/usage, E/M/W destination regs, load flags,
//            mult/div start, imem/dmem waits, exception redirect.
//   Outputs: stallF/D/E/M, flushD/E/M, decode comparator forward selects
//            fwd_d_a/b, md_busy.
//   Build option: DECODE_BRANCH_FWD_EN adds M/W forwarding into the decode
//   comparator; without it every early-use dependency stalls until writeback.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_ra1,
    input  logic [4:0] d_ra2,
    input  logic       d_use_rs,
    input  logic       d_use_rt,
    input  logic       d_use_rs_early,
    input  logic       d_use_rt_early,
    input  logic       d_reads_hilo,
    input  logic [4:0] e_wa,
    input  logic [4:0] m_wa,
    input  logic [4:0] w_wa,
    input  logic       e_regwrite,
    input  logic       m_regwrite,
    input  logic       w_regwrite,
    input  logic       e_memread,
    input  logic       m_memread,
    input  logic       e_md_start,
    input  logic       e_md_is_div,
    input  logic       i_stall,
    input  logic       d_stall,
    input  logic       exc_flush,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic [1:0] fwd_d_a,
    output logic [1:0] fwd_d_b,
    output logic       md_busy
);

    // Per-source, per-producer matches.
    logic e_a, e_b, m_a, m_b, w_a, w_b;
    assign e_a = reg_match(e_regwrite, e_wa, d_ra1);
    assign e_b = reg_match(e_regwrite, e_wa, d_ra2);
    assign m_a = reg_match(m_regwrite, m_wa, d_ra1);
    assign m_b = reg_match(m_regwrite, m_wa, d_ra2);
    assign w_a = reg_match(w_regwrite, w_wa, d_ra1);
    assign w_b = reg_match(w_regwrite, w_wa, d_ra2);

    logic load_use, early_haz, md_haz, hazard, freeze;
    logic nofwd_a, nofwd_b;
    fwd_sel_t fwd_a, fwd_b;

    assign load_use = e_memread &&
                      (((d_use_rs || d_use_rs_early) && e_a) ||
                       ((d_use_rt || d_use_rt_early) && e_b));

`ifdef DECODE_BRANCH_FWD_EN
    assign nofwd_a = 1'b0;
    assign nofwd_b = 1'b0;

    // A load in M has no data yet; that case stalls below instead.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (d_use_rs_early) begin
            if (m_a)      fwd_a = m_memread ? FWD_RF : FWD_M;
            else if (w_a) fwd_a = FWD_W;
        end
        if (d_use_rt_early) begin
            if (m_b)      fwd_b = m_memread ? FWD_RF : FWD_M;
            else if (w_b) fwd_b = FWD_W;
        end
    end
`else
    // No comparator bypass: wait until the producer has left W.
    assign nofwd_a = m_a || w_a;
    assign nofwd_b = m_b || w_b;
    assign fwd_a   = FWD_RF;
    assign fwd_b   = FWD_RF;
`endif

    assign early_haz = (d_use_rs_early && (e_a || (m_a && m_memread) || nofwd_a)) ||
                       (d_use_rt_early && (e_b || (m_b && m_memread) || nofwd_b));

    logic busy_raw, md_start;

    // A frozen or squashed E stage must not launch the unit.
    assign md_start = e_md_start && !freeze && !exc_flush;

    md_tracker #(
        .DIV_CYCLES (DIV_CYCLES),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_md (
        .clk      (clk),
        .reset    (reset),
        .start_i  (md_start),
        .is_div_i (e_md_is_div),
        .kill_i   (exc_flush),
        .busy_o   (busy_raw)
    );

    assign md_busy = busy_raw && !reset;
    assign md_haz  = md_busy && (d_reads_hilo || e_md_start);
    assign hazard  = load_use || early_haz || md_haz;
    assign freeze  = i_stall || d_stall;

    always_comb begin
        stallF  = 1'b0;
        stallD  = 1'b0;
        stallE  = 1'b0;
        stallM  = 1'b0;
        flushD  = 1'b0;
        flushE  = 1'b0;
        flushM  = 1'b0;
        fwd_d_a = fwd_a;
        fwd_d_b = fwd_b;
        if (reset) begin
            flushD  = 1'b1;
            flushE  = 1'b1;
            flushM  = 1'b1;
            fwd_d_a = FWD_RF;
            fwd_d_b = FWD_RF;
        end else if (exc_flush) begin
            // Fetch still cannot advance without an imem response.
            stallF = i_stall;
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (freeze) begin
            // Hold everything; a pending bubble is reissued after the freeze.
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (hazard) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

`ifdef DECODE_BRANCH_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] ra1, ra2;
        logic       use_rs, use_rt, early_rs, early_rt, hilo;
        logic [4:0] e_wa, m_wa, w_wa;
        logic       e_rw, m_rw, w_rw, e_mr, m_mr;
        logic       md_start, md_div, i_st, d_st, exc;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [3:0] st;
        logic [2:0] fl;
        logic [1:0] fa, fb;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    in_t  cur = '0;
    logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, md_busy;
    logic [1:0] fwd_d_a, fwd_d_b;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[20];
    int nv = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.DIV_CYCLES(32), .MUL_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .d_ra1(cur.ra1), .d_ra2(cur.ra2),
        .d_use_rs(cur.use_rs), .d_use_rt(cur.use_rt),
        .d_use_rs_early(cur.early_rs), .d_use_rt_early(cur.early_rt),
        .d_reads_hilo(cur.hilo),
        .e_wa(cur.e_wa), .m_wa(cur.m_wa), .w_wa(cur.w_wa),
        .e_regwrite(cur.e_rw), .m_regwrite(cur.m_rw), .w_regwrite(cur.w_rw),
        .e_memread(cur.e_mr), .m_memread(cur.m_mr),
        .e_md_start(cur.md_start), .e_md_is_div(cur.md_div),
        .i_stall(cur.i_st), .d_stall(cur.d_st), .exc_flush(cur.exc),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .fwd_d_a(fwd_d_a), .fwd_d_b(fwd_d_b), .md_busy(md_busy)
    );

    task automatic chk(input string nm, input logic [3:0] st, input logic [2:0] fl,
                       input logic [1:0] fa, input logic [1:0] fb, input logic busy);
        logic [11:0] got, exp;
        got = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, fwd_d_a, fwd_d_b, md_busy};
        exp = {st, fl, fa, fb, busy};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got stall=%b flush=%b fa=%b fb=%b busy=%b, want stall=%b flush=%b fa=%b fb=%b busy=%b",
                     nm, got[11:8], got[7:5], got[4:3], got[2:1], got[0], st, fl, fa, fb, busy);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string nm, input in_t i, input logic [3:0] st,
                       input logic [2:0] fl, input logic [1:0] fa, input logic [1:0] fb);
        tbl[nv].name = nm;
        tbl[nv].in   = i;
        tbl[nv].st   = st;
        tbl[nv].fl   = fl;
        tbl[nv].fa   = fa;
        tbl[nv].fb   = fb;
        nv++;
    endtask

    // Start a mult/div from idle; returns after the accepting edge.
    task automatic start_md(input logic is_div);
        cur = '{md_start:1'b1, md_div:is_div, default:'0};
        #2 chk(is_div ? "div_start" : "mul_start", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        tick();
        cur = '0;
    endtask

    in_t lu;

    initial begin
        lu = '{ra1:5'd2, ra2:5'd4, use_rs:1'b1, use_rt:1'b1, e_wa:5'd2, e_rw:1'b1, e_mr:1'b1, default:'0};

        add("idle",        '{ra1:5'd1, ra2:5'd2, use_rs:1'b1, use_rt:1'b1, default:'0}, 4'b0000, 3'b000, 2'b00, 2'b00);
        add("load_use_rs", lu, 4'b1100, 3'b010, 2'b00, 2'b00);
        add("alu_in_e",    '{ra1:5'd2, use_rs:1'b1, e_wa:5'd2, e_rw:1'b1, default:'0}, 4'b0000, 3'b000, 2'b00, 2'b00);
        add("load_r0",     '{use_rs:1'b1, e_rw:1'b1, e_mr:1'b1, default:'0}, 4'b0000, 3'b000, 2'b00, 2'b00);
        add("load_use_rt", '{ra2:5'd7, use_rt:1'b1, e_wa:5'd7, e_rw:1'b1, e_mr:1'b1, default:'0}, 4'b1100, 3'b010, 2'b00, 2'b00);
        add("load_no_we",  '{ra1:5'd2, use_rs:1'b1, e_wa:5'd2, e_mr:1'b1, default:'0}, 4'b0000, 3'b000, 2'b00, 2'b00);
        add("early_e_alu", '{ra1:5'd5, early_rs:1'b1, e_wa:5'd5, e_rw:1'b1, default:'0}, 4'b1100, 3'b010, 2'b00, 2'b00);
        add("early_m_load",'{ra1:5'd5, early_rs:1'b1, m_wa:5'd5, m_rw:1'b1, m_mr:1'b1, default:'0}, 4'b1100, 3'b010, 2'b00, 2'b00);
        add("early_m_alu", '{ra1:5'd5, early_rs:1'b1, m_wa:5'd5, m_rw:1'b1, default:'0},
            FWD ? 4'b0000 : 4'b1100, FWD ? 3'b000 : 3'b010, FWD ? 2'b01 : 2'b00, 2'b00);
        add("early_w_rt",  '{ra2:5'd9, early_rt:1'b1, w_wa:5'd9, w_rw:1'b1, default:'0},
            FWD ? 4'b0000 : 4'b1100, FWD ? 3'b000 : 3'b010, 2'b00, FWD ? 2'b10 : 2'b00);
        add("early_m_over_w", '{ra1:5'd5, early_rs:1'b1, m_wa:5'd5, m_rw:1'b1, w_wa:5'd5, w_rw:1'b1, default:'0},
            FWD ? 4'b0000 : 4'b1100, FWD ? 3'b000 : 3'b010, FWD ? 2'b01 : 2'b00, 2'b00);
        add("normal_m_alu", '{ra1:5'd5, use_rs:1'b1, m_wa:5'd5, m_rw:1'b1, default:'0}, 4'b0000, 3'b000, 2'b00, 2'b00);
        add("hilo_idle",   '{hilo:1'b1, default:'0}, 4'b0000, 3'b000, 2'b00, 2'b00);
        add("istall",      '{i_st:1'b1, default:'0}, 4'b1111, 3'b000, 2'b00, 2'b00);
        lu.d_st = 1'b1;
        add("dstall_lu",   lu, 4'b1111, 3'b000, 2'b00, 2'b00);
        lu.d_st = 1'b0;
        lu.exc = 1'b1; lu.i_st = 1'b1;
        add("exc_istall_lu", lu, 4'b1000, 3'b111, 2'b00, 2'b00);
        lu.exc = 1'b0; lu.i_st = 1'b0;
        add("exc_only",    '{exc:1'b1, default:'0}, 4'b0000, 3'b111, 2'b00, 2'b00);

        // Reset state
        cur = lu;
        #2 chk("reset_pre_edge", 4'b0000, 3'b111, 2'b00, 2'b00, 1'b0);
        tick(); tick();
        chk("reset_held", 4'b0000, 3'b111, 2'b00, 2'b00, 1'b0);
        reset = 1'b0;
        cur = '0;
        tick();

        // Combinational vector table, FSM idle throughout
        for (int i = 0; i < nv; i++) begin
            cur = tbl[i].in;
            #2 chk(tbl[i].name, tbl[i].st, tbl[i].fl, tbl[i].fa, tbl[i].fb, 1'b0);
            tick();
        end

        // Load-use bubble for one cycle, then producer in M
        cur = lu;
        #2 chk("lu_seq_c1", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
        tick();
        cur = '{ra1:5'd2, ra2:5'd4, use_rs:1'b1, use_rt:1'b1, m_wa:5'd2, m_rw:1'b1, m_mr:1'b1, default:'0};
        #2 chk("lu_seq_c2", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        tick();

        // beq $5,$6 with ALU producer of $5 walking M -> W -> gone
        cur = '{ra1:5'd5, ra2:5'd6, early_rs:1'b1, early_rt:1'b1, m_wa:5'd5, m_rw:1'b1, default:'0};
        #2 chk("beq_m", FWD ? 4'b0000 : 4'b1100, FWD ? 3'b000 : 3'b010, FWD ? 2'b01 : 2'b00, 2'b00, 1'b0);
        tick();
        cur = '{ra1:5'd5, ra2:5'd6, early_rs:1'b1, early_rt:1'b1, w_wa:5'd5, w_rw:1'b1, default:'0};
        #2 chk("beq_w", FWD ? 4'b0000 : 4'b1100, FWD ? 3'b000 : 3'b010, FWD ? 2'b10 : 2'b00, 2'b00, 1'b0);
        tick();
        cur = '{ra1:5'd5, ra2:5'd6, early_rs:1'b1, early_rt:1'b1, default:'0};
        #2 chk("beq_clear", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        tick();

        // d_stall for 3 cycles over a load-use, bubble on the 4th
        cur = lu; cur.d_st = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2 chk("freeze_lu", 4'b1111, 3'b000, 2'b00, 2'b00, 1'b0);
            tick();
        end
        cur.d_st = 1'b0;
        #2 chk("freeze_lu_release", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
        tick();

        // div then mflo: 32 busy cycles, released on the 33rd
        start_md(1'b1);
        cur = '{hilo:1'b1, default:'0};
        for (int i = 1; i <= 32; i++) begin
            #2 chk("div_mflo_busy", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b1);
            tick();
        end
        #2 chk("div_mflo_release", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        tick();

        // mult: exactly 2 busy cycles
        start_md(1'b0);
        #2 chk("mul_busy1", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b1);
        tick();
        #2 chk("mul_busy2", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b1);
        tick();
        #2 chk("mul_done", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        tick();

        // exc_flush when the div counter reads 10
        start_md(1'b1);
        for (int i = 0; i < 21; i++) tick();
        cur = '{hilo:1'b1, exc:1'b1, default:'0};
        #2 chk("div_exc", 4'b0000, 3'b111, 2'b00, 2'b00, 1'b1);
        tick();
        cur = '{hilo:1'b1, default:'0};
        #2 chk("div_exc_after", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        tick();

        // Reset mid-div
        start_md(1'b1);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        cur = '{hilo:1'b1, default:'0};
        #2 chk("div_reset_held", 4'b0000, 3'b111, 2'b00, 2'b00, 1'b0);
        tick();
        reset = 1'b0;
        #2 chk("div_reset_after", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        tick();

        // Start together with exc_flush is discarded
        cur = '{md_start:1'b1, md_div:1'b1, exc:1'b1, default:'0};
        #2 chk("start_exc", 4'b0000, 3'b111, 2'b00, 2'b00, 1'b0);
        tick();
        cur = '{hilo:1'b1, default:'0};
        #2 chk("start_exc_after", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        tick();

        // Start during a memory freeze is not accepted
        cur = '{md_start:1'b1, md_div:1'b1, d_st:1'b1, default:'0};
        #2 chk("start_frozen", 4'b1111, 3'b000, 2'b00, 2'b00, 1'b0);
        tick();
        cur = '{hilo:1'b1, default:'0};
        #2 chk("start_frozen_after", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        tick();

        // Second start while busy: stall and bubble E
        start_md(1'b0);
        cur = '{md_start:1'b1, default:'0};
        #2 chk("start_while_busy", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall scheduler for the five-stage MIPS core (F/D/E/M/W, one branch delay slot). It watches register usage in decode and destination registers in E/M/W, and produces per-stage stall and flush controls plus decode-stage forwarding selects for the branch/jr comparator. It owns the multi-cycle mult/div occupancy counter and freezes the pipeline on instruction- and data-memory waits.

## Interface
- DIV_CYCLES, 32: divide latency in cycles, ≥2
- MUL_CYCLES, 2: multiply latency in cycles, ≥2
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- d_ra1, d_ra2  in  5  decode source registers (rs, rt)
- d_use_rs, d_use_rt  in  1  operand consumed in E
- d_use_rs_early, d_use_rt_early  in  1  operand consumed in D (branch compare, jr)
- d_reads_hilo  in  1  decode instr is mfhi/mflo/mthi/mtlo
- e_wa, m_wa, w_wa  in  5  destination register per stage
- e_regwrite, m_regwrite, w_regwrite  in  1  stage writes register file
- e_memread, m_memread  in  1  stage holds a load
- e_md_start, e_md_is_div  in  1  E holds mult/div; 1 = div
- i_stall, d_stall  in  1  imem / dmem response not ready
- exc_flush  in  1  exception/eret redirect from M
- stallF, stallD, stallE, stallM  out  1  hold stage register
- flushD, flushE, flushM  out  1  load bubble into stage register
- fwd_d_a, fwd_d_b  out  2  decode operand source: 00 regfile, 01 M result, 10 W result
- md_busy  out  1  mult/div unit occupied

## Operation
- Match rule: producer X matches source s iff X_regwrite && X_wa != 0 && X_wa == s.
- Load-use: e_memread and E matches a used source (normal or early) → stallF, stallD, flushE.
- Early-use hazard: early source matching E (any type) → stallF, stallD, flushE; matching M with m_memread → same.
- Mult/div FSM, states IDLE / BUSY; 6-bit down counter cnt.
  - IDLE, e_md_start && !stallE → BUSY, cnt = (e_md_is_div ? DIV_CYCLES : MUL_CYCLES) − 1.
  - BUSY: cnt decrements each cycle regardless of stalls; cnt == 0 → IDLE next edge.
  - md_busy = (state == BUSY).
  - md_busy && (d_reads_hilo || e_md_start) → stallF, stallD, flushE; a new e_md_start is accepted only from IDLE.
- Memory freeze: i_stall || d_stall → stallF/D/E/M = 1; flushE is suppressed (freeze, not bubble); the hazard bubble is reissued once the freeze lifts.
- exc_flush → flushD, flushE, flushM = 1, all hazard stalls cleared, FSM → IDLE (cnt = 0); stallF still follows i_stall.
- Priority: exc_flush > memory freeze > load-use / early-use / mult-div stall.
- Reset: FSM IDLE, cnt 0.

## Timing
- All outputs combinational from inputs and FSM state; state updates on posedge clk.
- While reset high: stall* = 0, flush* = 1, fwd_d_* = 00, md_busy = 0.
- Load-use stall lasts exactly 1 cycle when no other hazard is present.
- md_busy stays high for exactly N cycles after the accepting edge (N = DIV_CYCLES or MUL_CYCLES).
- Simultaneous exc_flush and e_md_start: the start is discarded and the FSM stays IDLE.

## Configuration
- DECODE_BRANCH_FWD_EN defined: early source matching M (non-load) → fwd = 01; else matching W → fwd = 10; M wins over W; no stall.
- Undefined: fwd_d_* tied 00; any early source match in E, M or W → stallF, stallD, flushE.

## Structure
- Shared pipeline package: fwd_sel_t enum (FWD_RF, FWD_M, FWD_W), md_state_t enum, width constant for cnt.
- One sub-module `md_tracker`: FSM plus counter, outputs md_busy.

## Test plan
- Load `lw $2` in E, `add $3,$2,$4` in D → stallF/stallD/flushE for 1 cycle; next cycle all 0.
- `beq $5,$6` in D, M writes $5 (ALU) → with macro: fwd_d_a = 01, no stall; without: 1-cycle stall, then a second stall when the producer is in W.
- `div` accepted, `mflo` next in D → stallF/D high for 32 cycles, md_busy high 32 cycles, released on cycle 33.
- d_stall high 3 cycles during load-use → all four stalls high, flushE 0; bubble issued on the 4th cycle.
- exc_flush at cnt = 10 of a div → flushD/E/M = 1, md_busy 0 next cycle.
- Reset asserted mid-div → next cycle md_busy 0, flush* 1 while reset high.
